// File: rtl/wb_gpio_in.sv
// Wishbone pipelined slave for board switches/buttons: 2-FF synchronised, per-bit
// debounced inputs with a stable-level register, sticky W1C edge flags and a debounce limit.
module wb_gpio_in #(
    parameter int              N          = 4,
    parameter int              DB_W       = 20,
    parameter logic [DB_W-1:0] DB_DEFAULT = 20'd50000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  gpio_i,
    input  logic          wb_cyc,
    input  logic          wb_stb,
    input  logic          wb_we,
    input  logic [31:0]   wb_adr,
    input  logic [3:0]    wb_sel,
    input  logic [31:0]   wb_dat_i,
    output logic [31:0]   wb_dat_o,
    output logic          wb_ack,
    output logic          wb_stall
);

    localparam logic [1:0] ADR_STATUS   = 2'd0;
    localparam logic [1:0] ADR_RISE     = 2'd1;
    localparam logic [1:0] ADR_FALL     = 2'd2;
    localparam logic [1:0] ADR_DEBOUNCE = 2'd3;

    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

    logic [N-1:0]    sync_p0;
    logic [N-1:0]    sync_p1;
    logic [N-1:0]    stable_p2;
    logic [N-1:0]    stable_nxt;
    logic [DB_W-1:0] cnt_p2  [N];
    logic [DB_W-1:0] cnt_nxt [N];
    logic [N-1:0]    rise;
    logic [N-1:0]    fall;
    logic [N-1:0]    rise_set;
    logic [N-1:0]    fall_set;
    logic [N-1:0]    rise_clr;
    logic [N-1:0]    fall_clr;
    logic [DB_W-1:0] lim;
    logic [DB_W-1:0] lim_nxt;

    logic            req;
    logic            wr;
    logic            rd;
    logic [1:0]      adr;
    logic [31:0]     wmask;
    logic [31:0]     wbits;
    logic [31:0]     rdata;
    logic            vld_p1;
    logic [31:0]     dat_p1;

    logic            unused_bits;
    assign unused_bits = ^{wb_adr[31:4], wb_adr[1:0], wbits, wmask};

    assign req   = wb_cyc & wb_stb;
    assign wr    = req & wb_we;
    assign rd    = req & ~wb_we;
    assign adr   = wb_adr[3:2];
    assign wmask = byte_mask(wb_sel);
    assign wbits = wb_dat_i & wmask;

    // Debounce: a differing level must persist for lim+1 cycles before it is accepted.
    always_comb begin
        stable_nxt = stable_p2;
        for (int i = 0; i < N; i++) begin
            cnt_nxt[i] = cnt_p2[i];
            if (sync_p1[i] == stable_p2[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt_p2[i] == lim) begin
                stable_nxt[i] = sync_p1[i];
                cnt_nxt[i]    = '0;
            end else begin
                cnt_nxt[i] = cnt_p2[i] + DB_W'(1);
            end
        end
    end

    assign rise_set = stable_nxt & ~stable_p2;
    assign fall_set = ~stable_nxt & stable_p2;

    always_comb begin
        rise_clr = '0;
        fall_clr = '0;
        lim_nxt  = lim;
        if (wr) begin
            case (adr)
                ADR_RISE:     rise_clr = wbits[N-1:0];
                ADR_FALL:     fall_clr = wbits[N-1:0];
                ADR_DEBOUNCE: lim_nxt  = (lim & ~wmask[DB_W-1:0]) | wbits[DB_W-1:0];
                default:      ;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (adr)
            ADR_STATUS:   rdata[N-1:0]    = stable_p2;
            ADR_RISE:     rdata[N-1:0]    = rise;
            ADR_FALL:     rdata[N-1:0]    = fall;
            ADR_DEBOUNCE: rdata[DB_W-1:0] = lim;
            default:      ;
        endcase
    end

    // Stage boundary: synchroniser, debounce state, flags and bus response all register here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0   <= '0;
            sync_p1   <= '0;
            stable_p2 <= '0;
            for (int i = 0; i < N; i++) begin
                cnt_p2[i] <= '0;
            end
            rise      <= '0;
            fall      <= '0;
            lim       <= DB_DEFAULT;
            vld_p1    <= 1'b0;
            dat_p1    <= '0;
        end else begin
            sync_p0   <= gpio_i;
            sync_p1   <= sync_p0;
            stable_p2 <= stable_nxt;
            for (int i = 0; i < N; i++) begin
                cnt_p2[i] <= cnt_nxt[i];
            end
            // Set after clear so a same-cycle edge wins over a W1C.
            rise      <= (rise & ~rise_clr) | rise_set;
            fall      <= (fall & ~fall_clr) | fall_set;
            lim       <= lim_nxt;
            vld_p1    <= req;
            dat_p1    <= rd ? rdata : 32'd0;
        end
    end

    assign wb_ack   = vld_p1;
    assign wb_dat_o = dat_p1;
    assign wb_stall = 1'b0;

endmodule

// File: tb/tb_wb_gpio_in.sv
// Directed bench for wb_gpio_in: register vector table plus hand-written sequences for
// reset, debounce timing, glitch rejection, W1C lanes, set/clear collision and bursts.
module tb_wb_gpio_in;

    logic        clk;
    logic        rst;
    logic [3:0]  gpio_i;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_adr;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack;
    logic        wb_stall;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [17];

    wb_gpio_in dut (
        .clk      (clk),
        .rst      (rst),
        .gpio_i   (gpio_i),
        .wb_cyc   (wb_cyc),
        .wb_stb   (wb_stb),
        .wb_we    (wb_we),
        .wb_adr   (wb_adr),
        .wb_sel   (wb_sel),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack   (wb_ack),
        .wb_stall (wb_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic wb_op(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                         input logic [31:0] dat, output logic ack_o, output logic [31:0] dat_o);
        wb_cyc   = 1'b1;
        wb_stb   = 1'b1;
        wb_we    = we;
        wb_adr   = adr;
        wb_sel   = sel;
        wb_dat_i = dat;
        @(posedge clk);
        #1;
        ack_o  = wb_ack;
        dat_o  = wb_dat_o;
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] adr, input string name, input logic [31:0] exp);
        logic        a;
        logic [31:0] d;
        wb_op(adr, 1'b0, 4'h0, 32'h0, a, d);
        chk({name, "_ack"}, {31'd0, a}, 32'd1);
        chk(name, d, exp);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat,
                      input string name);
        logic        a;
        logic [31:0] d;
        wb_op(adr, 1'b1, sel, dat, a, d);
        chk({name, "_ack"}, {31'd0, a}, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic        a;
        logic [31:0] d;
        logic [31:0] burst_exp [4];

        vecs[0]  = '{32'hC, 1'b1, 4'b0001, 32'h0000_0003, 32'h0};
        vecs[1]  = '{32'hC, 1'b0, 4'b0000, 32'h0,         32'h0000_C303};
        vecs[2]  = '{32'hC, 1'b1, 4'b0010, 32'h0000_AB00, 32'h0};
        vecs[3]  = '{32'hC, 1'b0, 4'b0000, 32'h0,         32'h0000_AB03};
        vecs[4]  = '{32'hC, 1'b1, 4'b0100, 32'h00FF_0000, 32'h0};
        vecs[5]  = '{32'hC, 1'b0, 4'b0000, 32'h0,         32'h000F_AB03};
        vecs[6]  = '{32'hC, 1'b1, 4'b1111, 32'hFFFF_FFFF, 32'h0};
        vecs[7]  = '{32'hC, 1'b0, 4'b0000, 32'h0,         32'h000F_FFFF};
        vecs[8]  = '{32'h0, 1'b1, 4'b1111, 32'hFFFF_FFFF, 32'h0};
        vecs[9]  = '{32'h0, 1'b0, 4'b0000, 32'h0,         32'h0};
        vecs[10] = '{32'h4, 1'b1, 4'b1111, 32'h0000_000F, 32'h0};
        vecs[11] = '{32'h4, 1'b0, 4'b0000, 32'h0,         32'h0};
        vecs[12] = '{32'h8, 1'b0, 4'b0000, 32'h0,         32'h0};
        vecs[13] = '{32'hC, 1'b1, 4'b1111, 32'h0000_0003, 32'h0};
        vecs[14] = '{32'hC, 1'b0, 4'b0000, 32'h0,         32'h0000_0003};
        vecs[15] = '{32'hC, 1'b1, 4'b1000, 32'hFFFF_FFFF, 32'h0};
        vecs[16] = '{32'hC, 1'b0, 4'b0000, 32'h0,         32'h0000_0003};

        rst = 1'b0; gpio_i = 4'h0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        wb_adr = 32'h0; wb_sel = 4'h0; wb_dat_i = 32'h0;
        #1 rst = 1'b1;

        // T1: reset state, reset during a pending read and during a write
        idle(3);
        chk("reset_ack", {31'd0, wb_ack}, 32'd0);
        chk("reset_dat", wb_dat_o, 32'd0);
        rst = 1'b0;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'hC;
        @(posedge clk); #1;
        chk("pre_rst_ack", {31'd0, wb_ack}, 32'd1);
        chk("pre_rst_dat", wb_dat_o, 32'd50000);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_ack", {31'd0, wb_ack}, 32'd0);
        chk("rst_mid_dat", wb_dat_o, 32'd0);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge clk) rst = 1'b0;
        idle(1);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 32'hC; wb_sel = 4'hF;
        wb_dat_i = 32'h7;
        #3 rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_wr_ack", {31'd0, wb_ack}, 32'd0);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(negedge clk) rst = 1'b0;
        idle(1);
        rd(32'hC, "t1_debounce", 32'd50000);
        rd(32'h0, "t1_status", 32'd0);

        // Register map / byte-lane vector table; leaves DEBOUNCE = 3
        for (int i = 0; i < 17; i++) begin
            wb_op(vecs[i].adr, vecs[i].we, vecs[i].sel, vecs[i].dat, a, d);
            chk($sformatf("vec%0d_ack", i), {31'd0, a}, 32'd1);
            if (!vecs[i].we) chk($sformatf("vec%0d_dat", i), d, vecs[i].exp);
        end

        // T2: exact debounce latency with a continuous STATUS read stream
        gpio_i = 4'b0001;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            chk($sformatf("t2_ack_k%0d", k), {31'd0, wb_ack}, 32'd1);
            chk($sformatf("t2_status_k%0d", k), wb_dat_o, (k >= 7) ? 32'd1 : 32'd0);
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        rd(32'h0, "t2_status", 32'h1);
        rd(32'h4, "t2_rise", 32'h1);
        rd(32'h8, "t2_fall", 32'h0);
        wr(32'h4, 4'b0001, 32'h1, "t2_clr");
        rd(32'h4, "t2_rise_clr", 32'h0);

        // T3: 3-cycle glitch rejected, 4-cycle pulse accepted
        gpio_i = 4'b0011;
        idle(3);
        gpio_i = 4'b0001;
        idle(10);
        rd(32'h0, "t3_status", 32'h1);
        rd(32'h4, "t3_rise", 32'h0);
        rd(32'h8, "t3_fall", 32'h0);
        gpio_i = 4'b0011;
        idle(4);
        gpio_i = 4'b0001;
        idle(12);
        rd(32'h0, "t3b_status", 32'h1);
        rd(32'h4, "t3b_rise", 32'h2);
        rd(32'h8, "t3b_fall", 32'h2);
        wr(32'h4, 4'b0001, 32'h2, "t3b_clr_rise");
        wr(32'h8, 4'b0001, 32'h2, "t3b_clr_fall");

        // T4: W1C with byte lanes
        gpio_i = 4'h0;
        idle(10);
        wr(32'h8, 4'b0001, 32'hF, "t4_clr_fall");
        gpio_i = 4'hF;
        idle(10);
        rd(32'h4, "t4_rise_all", 32'hF);
        wr(32'h4, 4'b0001, 32'h5, "t4_w1c");
        rd(32'h4, "t4_rise_a", 32'hA);
        wr(32'h4, 4'b0000, 32'hF, "t4_w1c_nosel");
        rd(32'h4, "t4_rise_nosel", 32'hA);
        wr(32'h4, 4'b1110, 32'hFFFF_FFFF, "t4_w1c_lanes");
        rd(32'h4, "t4_rise_lanes", 32'hA);
        wr(32'h4, 4'b0001, 32'hF, "t4_clr_all");
        rd(32'h4, "t4_rise_zero", 32'h0);

        // T5: set wins over a same-cycle W1C; a same-cycle read sees the old flag
        gpio_i = 4'b1011;
        idle(10);
        rd(32'h8, "t5_fall", 32'h4);
        wr(32'h8, 4'b0001, 32'h4, "t5_clr_fall");
        gpio_i = 4'b1111;
        idle(5);
        wr(32'h4, 4'b0001, 32'h4, "t5_coll_w1c");
        rd(32'h4, "t5_set_wins", 32'h4);
        gpio_i = 4'b1011;
        idle(10);
        wr(32'h4, 4'b0001, 32'h4, "t5_clr_rise");
        gpio_i = 4'b1111;
        idle(5);
        rd(32'h4, "t5_read_old", 32'h0);
        rd(32'h4, "t5_read_new", 32'h4);

        // T6: four back-to-back reads
        burst_exp[0] = 32'hF; burst_exp[1] = 32'h4; burst_exp[2] = 32'h4; burst_exp[3] = 32'h3;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wb_adr = 32'(k * 4);
            chk($sformatf("t6_stall_req%0d", k), {31'd0, wb_stall}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("t6_ack%0d", k), {31'd0, wb_ack}, 32'd1);
            chk($sformatf("t6_dat%0d", k), wb_dat_o, burst_exp[k]);
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        idle(1);
        chk("t6_ack_end", {31'd0, wb_ack}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
